// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a valid/ready byte FIFO feeds a
// START/DATA/STOP serialiser. Frames run back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [7:0]                    pi_data,
  input  logic                          pi_valid,
  output logic                          pi_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf_pulse
);

  localparam int DATA_W      = 8;
  localparam int BIT_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int BAUD_W      = $clog2(BIT_CNT_MAX + 1);
  localparam int IDX_W       = $clog2(DATA_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CNT_MAX - 1);
  localparam logic [AW:0]       DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   r_baud;
  logic [IDX_W-1:0]    r_bit;
  logic [IDX_W-1:0]    w_bit_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_tx;
  logic                w_tx_nxt;
  logic                w_pop;
  logic                w_push;
  logic                w_ready;
  logic                w_empty;
  logic                w_bit_end;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_cnt;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic                r_ovf;

  // Full blocks a push even if the serialiser pops in the same cycle.
  assign w_ready   = (r_cnt != DEPTH_CNT);
  assign w_empty   = (r_cnt == '0);
  assign w_push    = pi_valid && w_ready;
  assign w_bit_end = (r_baud == BAUD_LAST);

  assign pi_ready  = w_ready;
  assign tx        = r_tx;
  assign busy      = (r_state != IDLE) || !w_empty;
  assign fifo_cnt  = r_cnt;
  assign ovf_pulse = r_ovf;

  // FIFO storage write; data is not reset, only the pointers are.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pi_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Rejected write attempt flag, visible the cycle after the attempt.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_ovf <= 1'b0;
    else         r_ovf <= pi_valid && !w_ready;
  end

  // Baud counter: parked at 0 while idle, reloads on every bit boundary.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || r_state == IDLE) r_baud <= '0;
    else if (w_bit_end)             r_baud <= '0;
    else                            r_baud <= r_baud + 1'b1;
  end

  // Shift register: loaded from the FIFO head on pop, shifted after each data bit.
  always_ff @(posedge sys_clk) begin
    if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
    end else if (r_state == DATA && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

  // FSM state, bit index and registered line output.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state, pop request and next line level; tx is driven a cycle ahead
  // so that it changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == LAST_IDX) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
